// File: rtl/clk_ratio_monitor_if.sv
// rtl/clk_ratio_monitor_if.sv - divided-clock monitor signal bundle
//
// Groups the divided clock under test, its configuration/control inputs and
// the monitor's strobe/measurement/status outputs.
//   div_clk_in     divided clock under test (asynchronous to clk_in)
//   expected_half  expected half-period in clk_in cycles
//   clear_fault    one-cycle pulse, clears FAULT and restarts acquisition
//   rise_stb       one-cycle pulse per div_clk_in rising edge
//   fall_stb       one-cycle pulse per div_clk_in falling edge
//   half_period    last measured half-period
//   period_valid   one-cycle pulse when half_period updates
//   locked         ratio locked
//   fault          sticky fault flag
//   fault_code     00 none, 01 mismatch, 10 timeout, 11 duty error
// master: drives the inputs (stimulus side); slave: the monitor itself.
interface clk_ratio_monitor_if #(
  parameter int CNT_W = 8
);
  logic             div_clk_in;
  logic [CNT_W-1:0] expected_half;
  logic             clear_fault;
  logic             rise_stb;
  logic             fall_stb;
  logic [CNT_W-1:0] half_period;
  logic             period_valid;
  logic             locked;
  logic             fault;
  logic [1:0]       fault_code;

  modport master (
    output div_clk_in, expected_half, clear_fault,
    input  rise_stb, fall_stb, half_period, period_valid, locked, fault, fault_code
  );

  modport slave (
    input  div_clk_in, expected_half, clear_fault,
    output rise_stb, fall_stb, half_period, period_valid, locked, fault, fault_code
  );
endinterface

// File: rtl/clk_ratio_monitor.sv
// rtl/clk_ratio_monitor.sv - divided-clock ratio monitor with lock and fault detection
//
// Synchronizes div_clk_in into clk_in, emits rise/fall strobes, measures every
// half-period in clk_in cycles and locks once LOCK_COUNT consecutive halves
// equal expected_half. After lock a mismatch or a stuck clock raises a sticky
// fault. Optional macro DUTY_CHECK_EN adds a half-to-half symmetry check
// while locked (fault_code 11).
// Ports:
//   clk_in  system clock (divider source clock)
//   rst_n   synchronous active-low reset
//   bus     clk_ratio_monitor_if.slave, see the interface file for signals
module clk_ratio_monitor #(
  parameter int CNT_W      = 8,
  parameter int MAX_PERIOD = 255,
  parameter int LOCK_COUNT = 4
) (
  input logic                clk_in,
  input logic                rst_n,
  clk_ratio_monitor_if.slave bus
);
  localparam int               MW      = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
  localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {ACQUIRE, COUNT, LOCKED, FAULT} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic [MW-1:0]    r_match_cnt, w_match_nxt;
  logic             r_rise, r_fall;
  logic [CNT_W-1:0] r_half, w_half_nxt;
  logic             r_pv, w_pv_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_fault, w_fault_nxt;
  logic [1:0]       r_code, w_code_nxt;

  logic             w_edge;
  logic             w_hit;
  logic             w_timeout;
  logic [MW-1:0]    w_match_inc;

  assign w_edge      = r_s2 ^ r_s3;
  assign w_hit       = (r_cnt == bus.expected_half);
  assign w_timeout   = (r_cnt == MAX_CNT);
  assign w_match_inc = r_match_cnt + MW'(1);

`ifdef DUTY_CHECK_EN
  // r_half still holds the previous measurement when the current one is judged.
  logic [CNT_W-1:0] w_diff;
  logic             w_duty_bad;
  assign w_diff     = (r_cnt >= r_half) ? (r_cnt - r_half) : (r_half - r_cnt);
  assign w_duty_bad = (w_diff > CNT_W'(1));
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_cnt       <= '0;
      r_match_cnt <= '0;
      r_state     <= ACQUIRE;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_half      <= '0;
      r_pv        <= 1'b0;
      r_locked    <= 1'b0;
      r_fault     <= 1'b0;
      r_code      <= 2'b00;
    end else begin
      r_s1        <= bus.div_clk_in;
      r_s2        <= r_s1;
      r_s3        <= r_s2;
      r_rise      <= r_s2 & ~r_s3;
      r_fall      <= ~r_s2 & r_s3;
      // Saturating counter: an edge restarts at 1 so cnt equals the half-period.
      if (w_edge)
        r_cnt <= CNT_W'(1);
      else if (!w_timeout)
        r_cnt <= r_cnt + CNT_W'(1);
      r_match_cnt <= w_match_nxt;
      r_state     <= w_state_nxt;
      r_half      <= w_half_nxt;
      r_pv        <= w_pv_nxt;
      r_locked    <= w_locked_nxt;
      r_fault     <= w_fault_nxt;
      r_code      <= w_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_match_nxt  = r_match_cnt;
    w_half_nxt   = r_half;
    w_pv_nxt     = 1'b0;
    w_locked_nxt = r_locked;
    w_fault_nxt  = r_fault;
    w_code_nxt   = r_code;
    case (r_state)
      ACQUIRE: begin
        // First edge only starts the measurement; nothing to report yet.
        if (w_edge) begin
          w_state_nxt = COUNT;
          w_match_nxt = '0;
        end
      end
      COUNT: begin
        if (w_edge) begin
          w_half_nxt = r_cnt;
          w_pv_nxt   = 1'b1;
          if (w_hit) begin
            w_match_nxt = w_match_inc;
            if (w_match_inc == LOCK_N) begin
              w_state_nxt  = LOCKED;
              w_locked_nxt = 1'b1;
            end
          end else begin
            w_match_nxt = '0;
          end
        end else if (w_timeout) begin
          w_state_nxt  = FAULT;
          w_locked_nxt = 1'b0;
          w_fault_nxt  = 1'b1;
          w_code_nxt   = 2'b10;
        end
      end
      LOCKED: begin
        if (w_edge) begin
          w_half_nxt = r_cnt;
          w_pv_nxt   = 1'b1;
`ifdef DUTY_CHECK_EN
          if (w_duty_bad) begin
            w_state_nxt  = FAULT;
            w_locked_nxt = 1'b0;
            w_fault_nxt  = 1'b1;
            w_code_nxt   = 2'b11;
          end else if (!w_hit) begin
            w_state_nxt  = FAULT;
            w_locked_nxt = 1'b0;
            w_fault_nxt  = 1'b1;
            w_code_nxt   = 2'b01;
          end
`else
          if (!w_hit) begin
            w_state_nxt  = FAULT;
            w_locked_nxt = 1'b0;
            w_fault_nxt  = 1'b1;
            w_code_nxt   = 2'b01;
          end
`endif
        end else if (w_timeout) begin
          w_state_nxt  = FAULT;
          w_locked_nxt = 1'b0;
          w_fault_nxt  = 1'b1;
          w_code_nxt   = 2'b10;
        end
      end
      FAULT: begin
        // Clear beats a coincident edge: that edge is dropped, not measured.
        if (bus.clear_fault) begin
          w_state_nxt = ACQUIRE;
          w_match_nxt = '0;
          w_fault_nxt = 1'b0;
          w_code_nxt  = 2'b00;
        end else if (w_edge) begin
          w_half_nxt = r_cnt;
          w_pv_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ACQUIRE;
    endcase
  end

  assign bus.rise_stb     = r_rise;
  assign bus.fall_stb     = r_fall;
  assign bus.half_period  = r_half;
  assign bus.period_valid = r_pv;
  assign bus.locked       = r_locked;
  assign bus.fault        = r_fault;
  assign bus.fault_code   = r_code;
endmodule

// File: tb/tb_clk_ratio_monitor.sv
// tb/tb_clk_ratio_monitor.sv - self-checking bench for clk_ratio_monitor
module tb_clk_ratio_monitor;
  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  clk_ratio_monitor_if #(.CNT_W(8)) bus ();

  clk_ratio_monitor #(.CNT_W(8), .MAX_PERIOD(255), .LOCK_COUNT(4)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  localparam int FLUSH = 6;
`ifdef DUTY_CHECK_EN
  localparam int CBIG = 3;
`else
  localparam int CBIG = 1;
`endif

  typedef struct {int h; bit lk; bit flt; int code;} vec_t;
  typedef struct {int half; bit lk; bit flt; int code;} pv_t;

  vec_t v[27];
  pv_t  pvq[$];
  int   sq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int outs();
    return int'({bus.rise_stb, bus.fall_stb, bus.half_period, bus.period_valid,
                 bus.locked, bus.fault, bus.fault_code});
  endfunction

  always @(posedge clk_in) begin
    #1;
    if (bus.period_valid)
      pvq.push_back('{int'(bus.half_period), bus.locked, bus.fault, int'(bus.fault_code)});
    if (bus.rise_stb || bus.fall_stb)
      sq.push_back(int'({bus.rise_stb, bus.fall_stb}));
  end

  task automatic set(input int i, input int h, input bit lk, input bit flt, input int code);
    v[i] = '{h, lk, flt, code};
  endtask

  // Acquisition toggle, then one toggle after each half; checks every period_valid.
  task automatic run_seg(input int first, input int last, input string tag);
    int start;
    int errs;
    pvq.delete();
    sq.delete();
    start = int'(bus.div_clk_in);
    bus.div_clk_in = ~bus.div_clk_in;
    for (int i = first; i <= last; i++) begin
      repeat (v[i].h) tick();
      bus.div_clk_in = ~bus.div_clk_in;
    end
    repeat (FLUSH) tick();
    chk({tag, "_pv_count"}, pvq.size(), last - first + 1);
    for (int i = first; i <= last; i++) begin
      if (i - first < pvq.size()) begin
        chk($sformatf("%s_half[%0d]", tag, i), pvq[i-first].half, v[i].h);
        chk($sformatf("%s_locked[%0d]", tag, i), int'(pvq[i-first].lk), int'(v[i].lk));
        chk($sformatf("%s_fault[%0d]", tag, i), int'(pvq[i-first].flt), int'(v[i].flt));
        chk($sformatf("%s_code[%0d]", tag, i), pvq[i-first].code, v[i].code);
      end
    end
    chk({tag, "_strobe_count"}, sq.size(), last - first + 2);
    errs = 0;
    for (int j = 0; j < sq.size(); j++)
      if (sq[j] != (((start ^ (j % 2)) == 0) ? 2 : 1)) errs++;
    chk({tag, "_strobe_order_errs"}, errs, 0);
  endtask

  initial begin
    set(0, 4, 0, 0, 0); set(1, 4, 0, 0, 0); set(2, 4, 0, 0, 0); set(3, 4, 1, 0, 0);
    set(4, 4, 1, 0, 0); set(5, 6, 0, 1, CBIG); set(6, 4, 0, 1, CBIG);
    set(7, 4, 0, 0, 0); set(8, 4, 0, 0, 0); set(9, 5, 0, 0, 0); set(10, 4, 0, 0, 0);
    set(11, 4, 0, 0, 0); set(12, 4, 0, 0, 0); set(13, 4, 1, 0, 0);
    set(14, 4, 0, 0, 0); set(15, 4, 0, 0, 0); set(16, 4, 0, 0, 0); set(17, 4, 1, 0, 0);
    set(18, 4, 0, 0, 0); set(19, 4, 0, 0, 0); set(20, 4, 0, 0, 0); set(21, 4, 1, 0, 0);
    set(22, 4, 0, 0, 0); set(23, 4, 0, 0, 0); set(24, 4, 0, 0, 0); set(25, 4, 1, 0, 0);
    set(26, 2, 0, 1, CBIG);

    bus.div_clk_in    = 1'b0;
    bus.expected_half = 8'd4;
    bus.clear_fault   = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;

    // Lock on 4s, then a 6-cycle half faults
    run_seg(0, 6, "t1");
    chk("t1_fault_held", int'(bus.fault), 1);
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    chk("clear_status", int'({bus.locked, bus.fault, bus.fault_code}), 0);

    // 4,4,5,4,4,4,4: match count restarts at the 5
    run_seg(7, 13, "t2");

    // Stuck clock while locked: last toggle was FLUSH ticks ago
    pvq.delete();
    sq.delete();
    repeat (257 - FLUSH) tick();
    chk("timeout_not_yet", int'(bus.fault), 0);
    chk("timeout_still_locked", int'(bus.locked), 1);
    tick();
    chk("timeout_fault", int'(bus.fault), 1);
    chk("timeout_code", int'(bus.fault_code), 2);
    chk("timeout_unlocked", int'(bus.locked), 0);
    chk("timeout_no_pv", pvq.size(), 0);
    chk("timeout_no_strobes", sq.size(), 0);

    // clear_fault coincident with an edge: edge dropped, reacquire on the next
    pvq.delete();
    bus.div_clk_in = ~bus.div_clk_in;
    repeat (2) tick();
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    tick();
    chk("clear_edge_no_pv", pvq.size(), 0);
    chk("clear_edge_fault", int'(bus.fault), 0);
    run_seg(14, 17, "t3");

    // One-cycle reset while locked
    rst_n = 1'b0;
    bus.div_clk_in = 1'b0;
    tick();
    chk("midrun_reset_outputs", outs(), 0);
    rst_n = 1'b1;
    run_seg(18, 21, "t4");

    // Locked then halves 4, 2
    rst_n = 1'b0;
    bus.div_clk_in = 1'b0;
    tick();
    rst_n = 1'b1;
    run_seg(22, 26, "t5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks so far", n_pass, n_total);
    $fatal(1);
  end
endmodule
